// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter with begin-window and transaction watchdog
//   cpuClock/cpuReset         : clock, synchronous active-high reset
//   busRequests   (in,  N)    : level-held per-master requests
//   busGrants     (out, N)    : one-cycle one-hot grant pulse
//   grantedMaster (out, 3)    : index of current or last bus owner
//   busBusy       (out, 1)    : high from grant until the transaction closes
//   beginTransactionIn/endTransactionIn/dataValidIn/busErrorIn : bus activity strobes
//   busErrorOut   (out, 1)    : one-cycle error strobe on watchdog expiry
//   timeoutCount  (out, 8)    : saturating count of watchdog expiries
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int BEGIN_WINDOW   = 3
) (
    input  logic                   cpuClock,
    input  logic                   cpuReset,
    input  logic [NUM_MASTERS-1:0] busRequests,
    output logic [NUM_MASTERS-1:0] busGrants,
    output logic [2:0]             grantedMaster,
    output logic                   busBusy,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    input  logic                   dataValidIn,
    input  logic                   busErrorIn,
    output logic                   busErrorOut,
    output logic [7:0]             timeoutCount
);
    localparam int BW_W = ($clog2(BEGIN_WINDOW + 1) > 2) ? $clog2(BEGIN_WINDOW + 1) : 2;

    typedef enum logic [2:0] {IDLE, GRANT, WAIT_BEGIN, BUSY, TIMEOUT} state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grants_q;
    logic [2:0]             granted_q;
    logic [2:0]             last_owner_q;
    logic                   busy_q;
    logic                   err_q;
    logic [7:0]             tcount_q;
    logic [7:0]             wd_q;
    logic [BW_W-1:0]        bw_q;

    logic [2:0] win_d;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    logic       hi_hit;
    logic [7:0] wd_inc;

    // Round-robin pick: lowest requester above the last owner, else lowest requester overall.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_hit = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (busRequests[i]) begin
                lo_idx = 3'(i);
                if (3'(i) > last_owner_q) begin
                    hi_idx = 3'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        win_d = hi_hit ? hi_idx : lo_idx;
    end

    // Watchdog expires on the cycle whose increment would reach the limit,
    // so the registered error lands TIMEOUT_CYCLES+1 cycles after last activity.
    assign wd_inc = wd_q + 8'd1;

    always_ff @(posedge cpuClock) begin
        if (cpuReset) begin
            state_q      <= IDLE;
            grants_q     <= '0;
            granted_q    <= '0;
            last_owner_q <= 3'(NUM_MASTERS - 1);
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            tcount_q     <= '0;
            wd_q         <= '0;
            bw_q         <= '0;
        end else begin
            grants_q <= '0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|busRequests) begin
                        state_q      <= GRANT;
                        grants_q     <= NUM_MASTERS'(1) << win_d;
                        granted_q    <= win_d;
                        last_owner_q <= win_d;
                        busy_q       <= 1'b1;
                    end
                end
                GRANT: begin
                    state_q <= WAIT_BEGIN;
                    bw_q    <= '0;
                end
                WAIT_BEGIN: begin
                    if (beginTransactionIn) begin
                        state_q <= BUSY;
                        wd_q    <= '0;
                    end else if (bw_q == BW_W'(BEGIN_WINDOW - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        bw_q <= bw_q + BW_W'(1);
                    end
                end
                BUSY: begin
                    if (endTransactionIn) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (dataValidIn || busErrorIn) begin
                        wd_q <= '0;
                    end else if (wd_inc == 8'(TIMEOUT_CYCLES)) begin
                        state_q  <= TIMEOUT;
                        err_q    <= 1'b1;
                        tcount_q <= (tcount_q == 8'hFF) ? tcount_q : tcount_q + 8'd1;
                        wd_q     <= '0;
                    end else begin
                        wd_q <= wd_inc;
                    end
                end
                TIMEOUT: begin
                    if (endTransactionIn || wd_inc == 8'(TIMEOUT_CYCLES)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        wd_q <= wd_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busGrants     = grants_q;
    assign grantedMaster = granted_q;
    assign busBusy       = busy_q;
    assign busErrorOut   = err_q;
    assign timeoutCount  = tcount_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: scoreboard bench for bus_arbiter_rr with a round-robin reference model
module tb_bus_arbiter_rr;
    localparam int N = 4;
    localparam int T = 8;

    logic         cpuClock;
    logic         cpuReset;
    logic [N-1:0] busRequests;
    logic [N-1:0] busGrants;
    logic [2:0]   grantedMaster;
    logic         busBusy;
    logic         beginTransactionIn;
    logic         endTransactionIn;
    logic         dataValidIn;
    logic         busErrorIn;
    logic         busErrorOut;
    logic [7:0]   timeoutCount;

    bus_arbiter_rr #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T), .BEGIN_WINDOW(3)) dut (
        .cpuClock(cpuClock),
        .cpuReset(cpuReset),
        .busRequests(busRequests),
        .busGrants(busGrants),
        .grantedMaster(grantedMaster),
        .busBusy(busBusy),
        .beginTransactionIn(beginTransactionIn),
        .endTransactionIn(endTransactionIn),
        .dataValidIn(dataValidIn),
        .busErrorIn(busErrorIn),
        .busErrorOut(busErrorOut),
        .timeoutCount(timeoutCount)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ref_last = N - 1;
    int ref_tc   = 0;
    int gq[$];
    int eq[$];
    int mon_g;
    int mon_e;
    logic [N-1:0] rnd_req;
    int rnd_mode;

    initial cpuClock = 1'b0;
    always #5 cpuClock = ~cpuClock;
    always @(posedge cpuClock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge cpuClock);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int idx = (ref_last + k) % N;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic void expect_grant(input logic [N-1:0] r);
        int w = pick(r);
        gq.push_back(w);
        ref_last = w;
    endfunction

    // Monitor: every grant or error the DUT presents is matched against the scoreboard.
    always @(negedge cpuClock) begin
        if (!cpuReset && busGrants != '0) begin
            if (gq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL grant_unexpected: busGrants=%b expected none", busGrants);
            end else begin
                mon_g = gq.pop_front();
                chk("grant_onehot", busGrants, N'(1) << mon_g);
                chk("granted_master", grantedMaster, mon_g);
            end
        end
        if (!cpuReset && busErrorOut) begin
            if (eq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL error_unexpected: busErrorOut=1 expected 0");
            end else begin
                mon_e = eq.pop_front();
                chk("timeout_count", timeoutCount, mon_e);
            end
        end
    end

    task automatic wait_grant(output int g);
        g = -1;
        for (int k = 0; k < 40 && g < 0; k++) begin
            @(negedge cpuClock);
            if (busGrants != '0) g = cyc;
        end
        chk("grant_seen", g >= 0, 1);
    endtask

    task automatic start_txn(input logic [N-1:0] r, output int g);
        expect_grant(r);
        busRequests = r;
        wait_grant(g);
        chk("busy_at_grant", busBusy, 1);
    endtask

    task automatic body_normal(input int beats, input int maxgap, input bit errend, input bit hold, output int e);
        tick();
        if (!hold) busRequests = '0;
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        for (int i = 0; i < beats; i++) begin
            repeat ($urandom_range(0, maxgap)) tick();
            dataValidIn = 1'b1;
            tick();
            dataValidIn = 1'b0;
        end
        endTransactionIn = 1'b1;
        busErrorIn = errend;
        e = cyc;
        @(negedge cpuClock);
        chk("busy_in_end_cycle", busBusy, 1);
        tick();
        endTransactionIn = 1'b0;
        busErrorIn = 1'b0;
        @(negedge cpuClock);
        chk("idle_after_end", busBusy, 0);
        chk("no_err_after_end", busErrorOut, 0);
    endtask

    task automatic run_normal(input logic [N-1:0] r, input int beats, input int maxgap, input bit errend);
        int g, e;
        start_txn(r, g);
        body_normal(beats, maxgap, errend, 1'b0, e);
    endtask

    task automatic do_fairness();
        int g, e, last_e;
        busRequests = '1;
        for (int i = 0; i < 5; i++) expect_grant('1);
        last_e = -1;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g);
            if (i > 0) chk("turnaround", g, last_e + 2);
            body_normal(2, 0, 1'b0, i < 4, e);
            last_e = e;
        end
    endtask

    task automatic do_abandon(input logic [N-1:0] r);
        int g;
        start_txn(r, g);
        tick();
        busRequests = '0;
        while (cyc < g + 3) tick();
        @(negedge cpuClock);
        chk("busy_in_window", busBusy, 1);
        tick();
        @(negedge cpuClock);
        chk("abandon_idle", busBusy, 0);
    endtask

    task automatic do_timeout(input logic [N-1:0] r, input bit send_end);
        int g, b, t;
        start_txn(r, g);
        tick();
        busRequests = '0;
        beginTransactionIn = 1'b1;
        b = cyc;
        ref_tc = (ref_tc < 255) ? ref_tc + 1 : 255;
        eq.push_back(ref_tc);
        tick();
        beginTransactionIn = 1'b0;
        t = -1;
        for (int k = 0; k < 40 && t < 0; k++) begin
            @(negedge cpuClock);
            if (busErrorOut) t = cyc;
        end
        chk("err_delay", t - b, T + 1);
        tick();
        @(negedge cpuClock);
        chk("err_single_pulse", busErrorOut, 0);
        chk("busy_in_timeout", busBusy, 1);
        if (send_end) begin
            tick();
            endTransactionIn = 1'b1;
            tick();
            endTransactionIn = 1'b0;
            @(negedge cpuClock);
            chk("timeout_end_idle", busBusy, 0);
        end else begin
            while (cyc < b + 2 * T) tick();
            @(negedge cpuClock);
            chk("timeout_hold", busBusy, 1);
            tick();
            @(negedge cpuClock);
            chk("timeout_self_exit", busBusy, 0);
        end
    endtask

    task automatic do_refresh(input logic [N-1:0] r);
        int g, b;
        start_txn(r, g);
        tick();
        busRequests = '0;
        beginTransactionIn = 1'b1;
        b = cyc;
        tick();
        beginTransactionIn = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            while (cyc < b + 7 * j) tick();
            dataValidIn = 1'b1;
            tick();
            dataValidIn = 1'b0;
        end
        while (cyc < b + 21 + T) tick();
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        @(negedge cpuClock);
        chk("refresh_end_idle", busBusy, 0);
        chk("refresh_tc", timeoutCount, ref_tc);
    endtask

    task automatic do_reset_mid(input logic [N-1:0] r);
        int g;
        start_txn(r, g);
        tick();
        busRequests = '0;
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            dataValidIn = 1'b1;
            if (i == 5) cpuReset = 1'b1;
            tick();
            dataValidIn = 1'b0;
            cpuReset = 1'b0;
        end
        ref_last = N - 1;
        ref_tc = 0;
        @(negedge cpuClock);
        chk("rst_mid_grants", busGrants, 0);
        chk("rst_mid_master", grantedMaster, 0);
        chk("rst_mid_busy", busBusy, 0);
        chk("rst_mid_err", busErrorOut, 0);
        chk("rst_mid_tc", timeoutCount, 0);
    endtask

    initial begin
        cpuReset = 1'b1;
        busRequests = '0;
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b0;
        dataValidIn = 1'b0;
        busErrorIn = 1'b0;
        repeat (2) tick();
        cpuReset = 1'b0;
        @(negedge cpuClock);
        chk("rst_grants", busGrants, 0);
        chk("rst_master", grantedMaster, 0);
        chk("rst_busy", busBusy, 0);
        chk("rst_err", busErrorOut, 0);
        chk("rst_tc", timeoutCount, 0);
        tick();
        run_normal(4'b0100, 16, 0, 1'b0);
        tick();
        do_fairness();
        tick();
        do_abandon(4'b0010);
        tick();
        run_normal(4'b1111, 2, 0, 1'b0);
        tick();
        do_timeout(4'b0001, 1'b1);
        chk("tc_after_timeout", timeoutCount, 1);
        tick();
        do_refresh(4'b1000);
        tick();
        run_normal(4'b0110, 3, 2, 1'b1);
        tick();
        do_reset_mid(4'b0110);
        tick();
        run_normal(4'b1111, 1, 0, 1'b0);
        for (int it = 0; it < 30; it++) begin
            tick();
            rnd_req = N'($urandom_range(1, 15));
            rnd_mode = $urandom_range(0, 9);
            if (rnd_mode <= 5) run_normal(rnd_req, $urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
            else if (rnd_mode == 6) do_abandon(rnd_req);
            else if (rnd_mode == 7) do_timeout(rnd_req, 1'($urandom_range(0, 1)));
            else if (rnd_mode == 8) do_refresh(rnd_req);
            else do_reset_mid(rnd_req);
        end
        repeat (4) tick();
        chk("scoreboard_drained", gq.size() + eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
